// File: rtl/bcd_multibyte_add_seq.sv
// Byte-serial packed-BCD adder: latches two NBYTES-byte operands, ripples the decimal carry LSB byte first,
// and returns sum/cout under valid/ready. Define BCD_CHECK_EN to add the sticky invalid-digit flag (err).
module bcd_multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout
`ifdef BCD_CHECK_EN
  ,
  output logic                  err
`endif
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  if (NBYTES < 1 || NBYTES > 16) begin : g_bad_nbytes
    $error("bcd_multibyte_add_seq: NBYTES must be in 1..16");
  end

  // FIN is the one-cycle commit of the final carry into cout.
  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_FIN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [8*NBYTES-1:0]   a_q, b_q, sum_q;
  logic [IW-1:0]         idx_q;
  logic                  carry_q, cout_q;
  logic [7:0]            cur_a, cur_b, byte_sum;
  logic [4:0]            lo_res, hi_res;
  logic                  accept;

  // Returns {carry, digit} for one decimal digit position.
  function automatic logic [4:0] digit_add(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, y} + {4'b0000, c};
    if (s > 5'd9) begin
      s = s + 5'd6;
      return {1'b1, s[3:0]};
    end
    return {1'b0, s[3:0]};
  endfunction

  assign accept = in_valid && (state_q == S_IDLE);

  assign cur_a    = a_q[8*idx_q +: 8];
  assign cur_b    = b_q[8*idx_q +: 8];
  assign lo_res   = digit_add(cur_a[3:0], cur_b[3:0], carry_q);
  assign hi_res   = digit_add(cur_a[7:4], cur_b[7:4], lo_res[4]);
  assign byte_sum = {hi_res[3:0], lo_res[3:0]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid)           state_d = S_ADD;
      S_ADD:  if (idx_q == LAST_IDX)  state_d = S_FIN;
      S_FIN:                          state_d = S_DONE;
      S_DONE: if (out_ready)          state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= cin;
      cout_q  <= 1'b0;
    end else if (state_q == S_ADD) begin
      sum_q[8*idx_q +: 8] <= byte_sum;
      carry_q             <= hi_res[4];
      idx_q               <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end else if (state_q == S_FIN) begin
      cout_q <= carry_q;
    end
  end

`ifdef BCD_CHECK_EN
  logic err_q;
  logic bad_digit;

  assign bad_digit = (cur_a[3:0] > 4'd9) || (cur_a[7:4] > 4'd9) ||
                     (cur_b[3:0] > 4'd9) || (cur_b[7:4] > 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  err_q <= 1'b0;
    else if (accept)             err_q <= 1'b0;
    else if (state_q == S_ADD)   err_q <= err_q | bad_digit;
  end

  assign err = err_q;
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
